// File: rtl/reg_window_stream.sv
// ---------------------------------------------------------------------------
// reg_window_stream
//
// Sliding-window register file for the conv front-end. Each accepted beat
// shifts LANES samples into the top of an N_REG-deep window; the whole window
// is exposed flattened on all_outputs for the MAC array. Once the window is
// full it is presented with win_valid and is only overwritten after the
// downstream consumes it (out_ready), so a stalled consumer backpressures the
// sample streamer through in_ready.
//
// Optional feature (macro REG_WINDOW_PAD_EN): a beat accepted with in_last
// starts end-of-frame zero padding. PAD_SHIFTS shifts of LANES zero samples
// follow, then the window and fill count are cleared and the block returns
// to FILL. Without the macro in_last is ignored and pad_busy is tied 0.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear of window, count and state
//   in_valid     in_data beat valid
//   in_ready     block can accept a beat
//   in_data      LANES samples, lane 0 (oldest) in the low bits
//   in_last      last beat of frame (padding build only)
//   win_valid    window holds N_REG samples not yet consumed
//   out_ready    downstream consumes the window this cycle
//   all_outputs  N_REG samples, reg 0 (oldest) in the low bits
//   fill_count   valid samples held, saturating at N_REG
//   pad_busy     zero padding in progress
// ---------------------------------------------------------------------------
module reg_window_stream #(
    parameter int WIDTH      = 32,
    parameter int N_REG      = 31,
    parameter int LANES      = 2,
    parameter int PAD_SHIFTS = 15,
    localparam int CNT_W     = $clog2(N_REG + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*LANES-1:0]   in_data,
    input  logic                     in_last,
    output logic                     win_valid,
    input  logic                     out_ready,
    output logic [WIDTH*N_REG-1:0]   all_outputs,
    output logic [CNT_W-1:0]         fill_count,
    output logic                     pad_busy
);

`ifdef REG_WINDOW_PAD_EN
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        PAD    = 2'd2
    } state_t;

    localparam int PAD_W = (PAD_SHIFTS > 0) ? $clog2(PAD_SHIFTS + 1) : 1;

    logic [PAD_W-1:0] pad_cnt_q;
    logic [PAD_W-1:0] pad_cnt_d;
    logic             pad_shift;
`else
    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int UNUSED_PAD_SHIFTS = PAD_SHIFTS;
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  fill_q;
    logic [CNT_W-1:0]  fill_d;
    logic              win_valid_q;
    logic              win_valid_d;
    logic [WIDTH-1:0]  win_q   [N_REG];
    logic [WIDTH-1:0]  shifted [N_REG];
    logic [WIDTH*LANES-1:0] shift_data;
    logic              shift_en;
    logic              zero_win;
    logic              room;
    logic              in_pad;
    logic              accept;
    logic              consume;
    logic [CNT_W:0]    fill_sum;
    logic [CNT_W-1:0]  fill_sat;

    // A new window may only be written when the current one is absent or is
    // being consumed in this same cycle.
    assign room    = !win_valid_q || out_ready;
    assign in_ready = room && !in_pad;
    assign accept  = in_valid && in_ready;
    assign consume = win_valid_q && out_ready;

`ifdef REG_WINDOW_PAD_EN
    assign in_pad     = (state_q == PAD);
    assign pad_busy   = in_pad;
    assign shift_data = pad_shift ? '0 : in_data;
`else
    assign in_pad     = 1'b0;
    assign pad_busy   = 1'b0;
    assign shift_data = in_data;
`endif

    // Count after one more shift; once streaming the count is already pinned.
    assign fill_sum = {1'b0, fill_q} + (CNT_W+1)'(LANES);
    assign fill_sat = ((state_q == STREAM) || (fill_sum > (CNT_W+1)'(N_REG)))
                    ? CNT_W'(N_REG) : fill_sum[CNT_W-1:0];

    // Shifted window: older samples move down by LANES, the incoming lanes
    // land in the top LANES registers (lane 0 is the oldest of them).
    for (genvar g = 0; g < N_REG; g++) begin : g_win
        if (g < N_REG - LANES) begin : g_keep
            assign shifted[g] = win_q[g + LANES];
        end else begin : g_load
            assign shifted[g] = shift_data[(g - (N_REG - LANES))*WIDTH +: WIDTH];
        end
        assign all_outputs[g*WIDTH +: WIDTH] = win_q[g];
    end

    assign fill_count = fill_q;
    assign win_valid  = win_valid_q;

    // Next-state logic. clr outranks everything, then padding, then a normal
    // accept, and finally a bare consume which only retires the window.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        win_valid_d = win_valid_q;
        shift_en    = 1'b0;
        zero_win    = 1'b0;
`ifdef REG_WINDOW_PAD_EN
        pad_cnt_d   = pad_cnt_q;
        pad_shift   = 1'b0;
`endif
        if (clr) begin
            state_d     = FILL;
            fill_d      = '0;
            win_valid_d = 1'b0;
            zero_win    = 1'b1;
`ifdef REG_WINDOW_PAD_EN
            pad_cnt_d   = '0;
`endif
        end
`ifdef REG_WINDOW_PAD_EN
        else if (state_q == PAD) begin
            // Zero shifts pace themselves on the consumer just like real beats;
            // the final clear waits until the last padded window is taken.
            if (pad_cnt_q != PAD_W'(PAD_SHIFTS)) begin
                if (room) begin
                    shift_en    = 1'b1;
                    pad_shift   = 1'b1;
                    pad_cnt_d   = pad_cnt_q + PAD_W'(1);
                    fill_d      = fill_sat;
                    win_valid_d = (fill_sat == CNT_W'(N_REG));
                end
            end else if (room) begin
                zero_win    = 1'b1;
                fill_d      = '0;
                win_valid_d = 1'b0;
                pad_cnt_d   = '0;
                state_d     = FILL;
            end
        end
`endif
        else if (accept) begin
            shift_en    = 1'b1;
            fill_d      = fill_sat;
            win_valid_d = (fill_sat == CNT_W'(N_REG));
            state_d     = (fill_sat == CNT_W'(N_REG)) ? STREAM : FILL;
`ifdef REG_WINDOW_PAD_EN
            if (in_last) begin
                state_d   = PAD;
                pad_cnt_d = '0;
            end
`endif
        end else if (consume) begin
            win_valid_d = 1'b0;
        end
    end

    // State, count and window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            fill_q      <= '0;
            win_valid_q <= 1'b0;
`ifdef REG_WINDOW_PAD_EN
            pad_cnt_q   <= '0;
`endif
            for (int i = 0; i < N_REG; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            win_valid_q <= win_valid_d;
`ifdef REG_WINDOW_PAD_EN
            pad_cnt_q   <= pad_cnt_d;
`endif
            if (zero_win) begin
                for (int i = 0; i < N_REG; i++) begin
                    win_q[i] <= '0;
                end
            end else if (shift_en) begin
                for (int i = 0; i < N_REG; i++) begin
                    win_q[i] <= shifted[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_window_stream.sv
// ---------------------------------------------------------------------------
// tb_reg_window_stream
//
// Directed bench for reg_window_stream with WIDTH=8, N_REG=5, LANES=2,
// PAD_SHIFTS=2. A small behavioural window model produces the expected
// state after each clock; expectations are queued at the clock edge and
// popped and compared just after it. Padding steps (REG_WINDOW_PAD_EN only)
// queue hand-derived windows.
// ---------------------------------------------------------------------------
module tb_reg_window_stream;

    localparam int WIDTH      = 8;
    localparam int N_REG      = 5;
    localparam int LANES      = 2;
    localparam int PAD_SHIFTS = 2;
    localparam int CNT_W      = 3;

    logic                     clk;
    logic                     rst_n;
    logic                     clr;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*LANES-1:0]   in_data;
    logic                     in_last;
    logic                     win_valid;
    logic                     out_ready;
    logic [WIDTH*N_REG-1:0]   all_outputs;
    logic [CNT_W-1:0]         fill_count;
    logic                     pad_busy;

    reg_window_stream #(
        .WIDTH      (WIDTH),
        .N_REG      (N_REG),
        .LANES      (LANES),
        .PAD_SHIFTS (PAD_SHIFTS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .win_valid   (win_valid),
        .out_ready   (out_ready),
        .all_outputs (all_outputs),
        .fill_count  (fill_count),
        .pad_busy    (pad_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] win;
        logic [2:0]  cnt;
        logic        wv;
        logic        ir;
        logic        pb;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [7:0] m [5];
    int         mcnt;
    bit         mvalid;

    function automatic logic [39:0] win5(input logic [7:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [39:0] packModel();
        logic [39:0] w;
        for (int i = 0; i < 5; i++) w[i*8 +: 8] = m[i];
        return w;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 5; i++) m[i] = 8'd0;
        mcnt   = 0;
        mvalid = 1'b0;
    endtask

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Pop one queued expectation and compare every observable output.
    task automatic checkOutput(input string tag);
        exp_t e;
        cmp({tag, "/queue"}, 64'(sb.size()), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        cmp({tag, "/window"},     64'(all_outputs), 64'(e.win));
        cmp({tag, "/fill_count"}, 64'(fill_count),  64'(e.cnt));
        cmp({tag, "/win_valid"},  64'(win_valid),   64'(e.wv));
        cmp({tag, "/in_ready"},   64'(in_ready),    64'(e.ir));
        cmp({tag, "/pad_busy"},   64'(pad_busy),    64'(e.pb));
    endtask

    // One clock of stimulus: drive on the falling edge, advance the model at
    // the rising edge, queue its prediction, check just after the edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d0, input logic [7:0] d1,
                                 input bit last, input bit ordy, input bit c,
                                 input string tag);
        bit acc;
        bit cons;
        @(negedge clk);
        in_valid  = v;
        in_data   = {d1, d0};
        in_last   = last;
        out_ready = ordy;
        clr       = c;
        acc  = v && (!mvalid || ordy);
        cons = mvalid && ordy;
        @(posedge clk);
        if (c) begin
            resetModel();
        end else if (acc) begin
            for (int i = 0; i < 3; i++) m[i] = m[i+2];
            m[3]   = d0;
            m[4]   = d1;
            mcnt   = (mcnt + 2 > 5) ? 5 : mcnt + 2;
            mvalid = (mcnt == 5);
        end else if (cons) begin
            mvalid = 1'b0;
        end
        sb.push_back('{packModel(), 3'(mcnt), mvalid, (!mvalid || ordy), 1'b0});
        #1;
        checkOutput(tag);
    endtask

    // Same timing, but with an explicitly supplied expectation.
    task automatic applyRaw(input bit v, input logic [7:0] d0, input logic [7:0] d1,
                            input bit last, input bit ordy, input exp_t e,
                            input string tag);
        @(negedge clk);
        in_valid  = v;
        in_data   = {d1, d0};
        in_last   = last;
        out_ready = ordy;
        clr       = 1'b0;
        @(posedge clk);
        sb.push_back(e);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        rst_n     = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Power-on reset.
        #1 rst_n = 1'b0;
        #2;
        cmp("reset/window",     64'(all_outputs), 64'd0);
        cmp("reset/fill_count", 64'(fill_count),  64'd0);
        cmp("reset/win_valid",  64'(win_valid),   64'd0);
        cmp("reset/pad_busy",   64'(pad_busy),    64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        cmp("reset/in_ready", 64'(in_ready), 64'd1);

        // Fill with the consumer stalled.
        applyStimulus(1, 8'd1, 8'd2, 0, 0, 0, "fill1");
        applyStimulus(1, 8'd3, 8'd4, 0, 0, 0, "fill2");
        applyStimulus(1, 8'd5, 8'd6, 0, 0, 0, "fill3");
        cmp("fill3/spec_window", 64'(all_outputs), 64'(win5(2, 3, 4, 5, 6)));
        cmp("fill3/spec_valid",  64'(win_valid),   64'd1);

        // Backpressure: held beat must not disturb the window.
        for (int k = 0; k < 4; k++) applyStimulus(1, 8'd7, 8'd8, 0, 0, 0, "stall");
        cmp("stall/spec_window", 64'(all_outputs), 64'(win5(2, 3, 4, 5, 6)));
        applyStimulus(1, 8'd7, 8'd8, 0, 1, 0, "release78");
        cmp("release78/spec_window", 64'(all_outputs), 64'(win5(4, 5, 6, 7, 8)));

        // Bare consume retires the window without touching it.
        applyStimulus(0, 8'd0, 8'd0, 0, 1, 0, "consume");
        cmp("consume/spec_valid",  64'(win_valid),   64'd0);
        cmp("consume/spec_window", 64'(all_outputs), 64'(win5(4, 5, 6, 7, 8)));

        // Synchronous clear, then clear colliding with an accept mid-fill.
        applyStimulus(0, 8'd0, 8'd0, 0, 0, 1, "clr");
        applyStimulus(1, 8'd1, 8'd2, 0, 0, 0, "refill");
        applyStimulus(1, 8'd3, 8'd4, 0, 0, 1, "clr_accept");
        cmp("clr_accept/spec_fill", 64'(fill_count), 64'd0);
        applyStimulus(0, 8'd0, 8'd0, 0, 0, 0, "clr_idle");

        // Stream with the consumer always ready, then async reset mid-stream.
        applyStimulus(1, 8'd11, 8'd12, 0, 1, 0, "stream1");
        applyStimulus(1, 8'd13, 8'd14, 0, 1, 0, "stream2");
        applyStimulus(1, 8'd15, 8'd16, 0, 1, 0, "stream3");
        cmp("stream3/spec_window", 64'(all_outputs), 64'(win5(12, 13, 14, 15, 16)));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst/window",     64'(all_outputs), 64'd0);
        cmp("async_rst/fill_count", 64'(fill_count),  64'd0);
        cmp("async_rst/win_valid",  64'(win_valid),   64'd0);
        cmp("async_rst/pad_busy",   64'(pad_busy),    64'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        resetModel();
        #1;
        cmp("async_rst/in_ready", 64'(in_ready), 64'd1);

`ifdef REG_WINDOW_PAD_EN
        // End-of-frame zero padding with the consumer always ready.
        applyStimulus(1, 8'd1, 8'd2, 0, 1, 0, "pad_pre1");
        applyStimulus(1, 8'd3, 8'd4, 0, 1, 0, "pad_pre2");
        applyRaw(1, 8'd5, 8'd6, 1, 1, '{win5(2, 3, 4, 5, 6), 3'd5, 1'b1, 1'b0, 1'b1}, "pad_enter");
        applyRaw(0, 8'd0, 8'd0, 0, 1, '{win5(4, 5, 6, 0, 0), 3'd5, 1'b1, 1'b0, 1'b1}, "pad_shift1");
        applyRaw(0, 8'd0, 8'd0, 0, 1, '{win5(6, 0, 0, 0, 0), 3'd5, 1'b1, 1'b0, 1'b1}, "pad_shift2");
        applyRaw(0, 8'd0, 8'd0, 0, 1, '{40'd0, 3'd0, 1'b0, 1'b1, 1'b0}, "pad_done");
        resetModel();
        applyStimulus(1, 8'd9, 8'd10, 0, 1, 0, "post_pad");
`else
        // in_last has no effect when padding is not built in.
        applyStimulus(1, 8'd21, 8'd22, 1, 0, 0, "last_ign1");
        applyStimulus(1, 8'd23, 8'd24, 1, 0, 0, "last_ign2");
        applyStimulus(1, 8'd25, 8'd26, 1, 0, 0, "last_ign3");
        cmp("last_ign3/spec_window", 64'(all_outputs), 64'(win5(22, 23, 24, 25, 26)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_window_stream.md
Name: reg_window_stream

Overview:
- Parametrised sliding-window register file for the conv front-end: shifts in LANES samples per accepted beat and exposes the full N_REG-deep window, flattened.
- Adds over the previous fixed two-input shift file: valid/ready input handshake, window-valid/consume handshake with backpressure, fill counter, and synchronous clear.
- Sits between the sample streamer and the MAC array. The window is only overwritten after downstream consumes it.

Parameters:
- WIDTH, 32, bits per sample (signed).
- N_REG, 31, window depth in samples; must satisfy N_REG >= LANES.
- LANES, 2, samples shifted in per accepted beat; range 1..N_REG.
- PAD_SHIFTS, 15, number of zero-lane shifts at end of frame. Used only with REG_WINDOW_PAD_EN.
- CNT_W (localparam), $clog2(N_REG+1), fill counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: registers, count and state return to reset values.
- in_valid  in  1  in_data beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH*LANES  lane k at bits [(k+1)*WIDTH-1 : k*WIDTH]; lane 0 is the oldest sample.
- in_last  in  1  last beat of frame. Ignored without REG_WINDOW_PAD_EN.
- win_valid  out  1  window holds N_REG samples not yet consumed.
- out_ready  in  1  downstream consumes the window this cycle when win_valid=1.
- all_outputs  out  WIDTH*N_REG  register N at [(N+1)*WIDTH-1 : N*WIDTH]; reg 0 is the oldest sample.
- fill_count  out  CNT_W  valid samples held, saturating at N_REG.
- pad_busy  out  1  zero-padding in progress. Tied 0 without the macro.

Behaviour:
- Reset (rst_n low, async): all registers 0; fill_count 0; win_valid 0; pad_busy 0; state FILL; in_ready 1 once rst_n is high.
- States: FILL (fill_count<N_REG), STREAM (fill_count==N_REG), PAD (macro only).
- Handshake:
  - in_ready = !win_valid | out_ready, forced 0 in PAD.
  - accept = in_valid & in_ready.
  - consume = win_valid & out_ready.
- Shift, on accept:
  - reg[i] <= reg[i+LANES] for i < N_REG-LANES.
  - reg[N_REG-LANES+k] <= lane k.
  - fill_count <= min(fill_count+LANES, N_REG).
- win_valid is registered:
  - Set on the cycle after a shift whose resulting count is N_REG.
  - Cleared after a consume with no shift in the same cycle.
  - Stays 1 when consume and shift coincide; the new window is visible the next cycle.
- Latency: accepted beat to all_outputs/fill_count update is 1 cycle.
- The window never changes while win_valid=1 and out_ready=0 (in_ready=0, stall).
- in_valid with in_ready=0: no state change. The upstream holds data.
- clr has priority over accept, consume and PAD in the same cycle.
- rst_n assertion mid-frame or mid-PAD aborts immediately to reset values.
- LANES == N_REG: every accepted beat replaces the whole window; count saturates after 1 beat.
- fill_count never exceeds N_REG.
- A partial last fill (N_REG not a multiple of LANES) still saturates the count, and the oldest samples are dropped.

Optional Feature:
- Macro: REG_WINDOW_PAD_EN.
- Defined:
  - Accepting a beat with in_last=1 enters PAD after that shift; pad_busy=1 and in_ready=0.
  - Each cycle where (!win_valid | out_ready) holds performs one shift of LANES zero samples, with the same count/win_valid rules as a normal shift.
  - After PAD_SHIFTS zero shifts, the next cycle clears registers and fill_count to 0, drops pad_busy and returns to FILL.
  - The final padded window must have been consumed before that clear.
- Not defined: in_last ignored, pad_busy tied 0, PAD state absent.

Test Plan:
All scenarios use WIDTH=8, N_REG=5, LANES=2, PAD_SHIFTS=2.
- Reset then feed (1,2),(3,4),(5,6) with out_ready=0:
  - fill_count goes 2,4,5.
  - all_outputs = [2,3,4,5,6] (reg0..4).
  - win_valid=1 on the cycle after the 3rd beat.
- Window valid, out_ready=0, in_valid=1 with (7,8) held for 4 cycles:
  - in_ready=0.
  - Window stays [2,3,4,5,6].
  - Raising out_ready accepts (7,8), and the window becomes [4,5,6,7,8].
- Window valid, out_ready=1, in_valid=0 for 1 cycle: win_valid drops to 0 and the window is unchanged.
- clr and accept in the same cycle mid-fill: all registers 0, fill_count 0, win_valid 0.
- rst_n pulsed low asynchronously (between clk edges) mid-stream: all outputs are 0 immediately, without waiting for a clock edge.
- With REG_WINDOW_PAD_EN and out_ready=1:
  - Beat (5,6) with in_last after (1,2),(3,4).
  - Next windows are [4,5,6,0,0] then [6,0,0,0,0].
  - pad_busy is then 0 with fill_count 0 and in_ready 1.
